// File: rtl/ser_pkg.sv
// Shared definitions for the serial word transmitter: FSM encodings and limits.
package ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_PAR   = 2'b10
  } state_t;

  localparam int WIDTH_MAX = 16;

endpackage

// File: rtl/serial_word_tx.sv
// Parallel-to-serial source, MSB first, feeding a downstream serial-in shift register.
// Define SERIAL_WORD_TX_PARITY_EN to append an even-parity bit to every word.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | no transmission in progress, D/D_VALID low
// ST_SHIFT | data bits on D, counter = index of bit shown
// ST_PAR   | parity bit on D (parity build only)
module serial_word_tx
  import ser_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  output logic             D,
  output logic             D_VALID,
  output logic             LAST
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             d_q, d_d;
  logic             dv_q, dv_d;
  logic             last_q, last_d;
  logic             at_last;
  logic             accept;
`ifdef SERIAL_WORD_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign at_last = (state_q == ST_SHIFT) && (cnt_q == CW'(WIDTH - 1));

`ifdef SERIAL_WORD_TX_PARITY_EN
  assign LOAD_READY = (state_q == ST_IDLE) || (state_q == ST_PAR);
`else
  assign LOAD_READY = (state_q == ST_IDLE) || at_last;
`endif

  assign accept  = LOAD_VALID && LOAD_READY;
  assign D       = d_q;
  assign D_VALID = dv_q;
  assign LAST    = last_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      d_q     <= 1'b0;
      dv_q    <= 1'b0;
      last_q  <= 1'b0;
`ifdef SERIAL_WORD_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      d_q     <= d_d;
      dv_q    <= dv_d;
      last_q  <= last_d;
`ifdef SERIAL_WORD_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    d_d     = 1'b0;
    dv_d    = 1'b0;
    last_d  = 1'b0;
`ifdef SERIAL_WORD_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (accept) begin
      // First bit goes straight to D; the shifter keeps only what is left.
      state_d = ST_SHIFT;
      cnt_d   = '0;
      sh_d    = {DIN[WIDTH-2:0], 1'b0};
      d_d     = DIN[WIDTH-1];
      dv_d    = 1'b1;
`ifdef SERIAL_WORD_TX_PARITY_EN
      par_d   = ^DIN;
`endif
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (at_last) begin
`ifdef SERIAL_WORD_TX_PARITY_EN
            state_d = ST_PAR;
            d_d     = par_q;
            dv_d    = 1'b1;
            last_d  = 1'b1;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
            d_d   = sh_q[WIDTH-1];
            sh_d  = {sh_q[WIDTH-2:0], 1'b0};
            dv_d  = 1'b1;
`ifndef SERIAL_WORD_TX_PARITY_EN
            last_d = (cnt_d == CW'(WIDTH - 1));
`endif
          end
        end
        ST_PAR:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Parallel-to-serial source that sits directly upstream of the 4-bit serial-in shift register stage and drives its D input.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per CLK, MSB first.
- Flags each valid bit and marks the final bit, so the downstream register holds a complete word after WIDTH shifts.

Parameters:
- WIDTH, 4, data word width in bits; legal range 2..16.

Ports:
- CLK  input  1  rising-edge clock, shared with the downstream shift register.
- RST  input  1  synchronous reset, active-high.
- DIN  input  WIDTH  parallel word to transmit.
- LOAD_VALID  input  1  DIN is valid this cycle.
- LOAD_READY  output  1  block can accept DIN this cycle (combinational from state).
- D  output  1  serial data bit; feeds the downstream D input.
- D_VALID  output  1  D carries a data or parity bit this cycle.
- LAST  output  1  D carries the final bit of the current word.

Behaviour:
- Clocking and reset: single clock CLK; reset RST is synchronous and active-high. All state changes occur on the rising CLK edge.
- Reset values: state=IDLE, shift register=0, bit counter=0, D=0, D_VALID=0, LAST=0.
- D, D_VALID and LAST are registered outputs.
- States:
  - IDLE: no transmission in progress.
  - SHIFT: data bits being sent.
  - PAR: parity bit being sent (exists only with the optional feature).
- Handshake: a word is accepted on a rising edge where LOAD_VALID=1 and LOAD_READY=1; DIN is captured into the internal shift register on that edge.
- LOAD_READY is 1 in two cases:
  - state=IDLE;
  - state=SHIFT with the counter at its last data bit and no parity stage pending.
  Otherwise LOAD_READY is 0.
- Latency: the first bit, DIN[WIDTH-1], appears on D with D_VALID=1 in the cycle immediately after the accept edge. DIN[WIDTH-2..0] follow on consecutive cycles, with no bubbles.
- Bit counter: width $clog2(WIDTH). It is cleared on accept and increments each SHIFT cycle. LAST=1 when counter=WIDTH-1, i.e. on the final data bit.
- Transitions:
  - IDLE -> SHIFT on accept.
  - SHIFT -> IDLE after the last bit when no new accept occurs.
  - SHIFT -> SHIFT (counter reloaded to 0) when a new accept coincides with the last bit: back-to-back words, zero gap.
- Idle output: in IDLE, D=0 and D_VALID=0.
- Busy: LOAD_VALID while LOAD_READY=0 is ignored. DIN is not sampled, and the word in flight is unaffected.
- Reset mid-word: RST=1 aborts the word on that edge. The next cycle shows the reset values; no partial LAST is emitted.
- Simultaneous RST and LOAD_VALID: reset wins and the word is dropped.
- DIN changing after acceptance has no effect.

Optional Feature:
- Macro: SERIAL_WORD_TX_PARITY_EN.
- Defined:
  - After the WIDTH data bits, the FSM enters PAR for one cycle. D = XOR of the captured word (even parity), D_VALID=1, LAST=1.
  - LAST is not asserted on the final data bit.
  - LOAD_READY is asserted during PAR, not on the final data bit, so back-to-back words accepted during PAR start with zero gap.
  - Frame length is WIDTH+1 cycles.
- Undefined: PAR state and parity logic are absent; frame length is WIDTH cycles.

Decomposition:
- Shared package/include ser_pkg: state encodings ST_IDLE=2'b00, ST_SHIFT=2'b01, ST_PAR=2'b10; constant WIDTH_MAX=16.
- No sub-module: the FSM, counter and shift register are small enough for one module.

Test Plan:
- Reset: hold RST=1 for 2 cycles -> D=0, D_VALID=0, LAST=0, LOAD_READY=1.
- Single word: DIN=4'b1011 with LOAD_VALID pulsed for one cycle -> next 4 cycles D=1,0,1,1 with D_VALID=1, LAST=1 only on the 4th; then D_VALID=0. The downstream register then holds 4'b1011.
- Back-to-back: 4'b1100 then 4'b0011 with LOAD_VALID held high -> 8 contiguous valid cycles, D=1,1,0,0,0,0,1,1, LAST on cycles 4 and 8, second accept coincides with cycle 4.
- Busy ignore: while 4'b1111 is shifting, present DIN=4'b0000 with LOAD_VALID=1 at bit 2 -> LOAD_READY=0, output stays 1,1,1,1, then 0000 is accepted at the LAST cycle.
- Reset mid-word: RST=1 on the 2nd bit of 4'b1010 -> next cycle D=0, D_VALID=0, LOAD_READY=1; no LAST is ever seen for that word.
- Parity (SERIAL_WORD_TX_PARITY_EN defined): DIN=4'b1011 -> D=1,0,1,1,1 over 5 cycles, LAST on the 5th only; DIN=4'b1001 -> 5th bit=0.
